// File: rtl/gate_classifier.sv
// rtl/gate_classifier.sv - drives all four vectors into a 2-input gate and classifies its truth table
module gate_classifier #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dut_y,
  output logic       dut_a,
  output logic       dut_b,
  output logic       busy,
  output logic       done,
  output logic [3:0] truth,
  output logic [2:0] code
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] LAST = 4'(SETTLE - 1);

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic [1:0] idx, idx_nx;
  logic [3:0] shadow, shadow_nx;
  logic [3:0] truth_nx, pub;
  logic [2:0] code_nx;
  logic       a_nx, b_nx, busy_nx, done_nx;

  function automatic logic [2:0] classify(input logic [3:0] t);
    case (t)
      4'b1000: return 3'd1;
      4'b1110: return 3'd2;
      4'b0111: return 3'd3;
      4'b0001: return 3'd4;
      4'b0110: return 3'd5;
      4'b1001: return 3'd6;
      default: return 3'd0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      idx    <= 2'd0;
      shadow <= 4'd0;
      dut_a  <= 1'b0;
      dut_b  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      truth  <= 4'd0;
      code   <= 3'd0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      idx    <= idx_nx;
      shadow <= shadow_nx;
      dut_a  <= a_nx;
      dut_b  <= b_nx;
      busy   <= busy_nx;
      done   <= done_nx;
      truth  <= truth_nx;
      code   <= code_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    idx_nx    = idx;
    shadow_nx = shadow;
    a_nx      = 1'b0;
    b_nx      = 1'b0;
    busy_nx   = 1'b0;
    done_nx   = 1'b0;
    truth_nx  = truth;
    code_nx   = code;
    pub       = {dut_y, shadow[2:0]};
    case (state)
      IDLE: begin
        if (start) begin
          state_nx  = RUN;
          cnt_nx    = 4'd0;
          idx_nx    = 2'd0;
          shadow_nx = 4'd0;
          busy_nx   = 1'b1;
        end
      end
      RUN: begin
        busy_nx = 1'b1;
        {a_nx, b_nx} = idx;
        if (cnt == LAST) begin
          // Last cycle of this vector: capture the gate output and advance.
          shadow_nx[idx] = dut_y;
          cnt_nx = 4'd0;
          if (idx == 2'd3) begin
            state_nx = DONE;
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
            a_nx     = 1'b0;
            b_nx     = 1'b0;
            truth_nx = pub;
            code_nx  = classify(pub);
          end else begin
            idx_nx = idx + 2'd1;
            {a_nx, b_nx} = idx + 2'd1;
          end
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gate_classifier.sv
// tb/tb_gate_classifier.sv - randomized self-checking bench for gate_classifier
module tb_gate_classifier;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start1 = 1'b0, start2 = 1'b0;
  logic       y1, y2, yr1, yr2;
  logic       a1, b1, busy1, done1, a2, b2, busy2, done2;
  logic [3:0] truth1, truth2;
  logic [2:0] code1, code2;

  int         g = 0;
  logic [3:0] tbl = 4'd0;
  logic       dly = 1'b0;
  int         sel = 1;
  int         checks = 0, errors = 0;
  int         lat, busy_n;
  logic [1:0] vq[$];

  logic       o_busy, o_done, o_a, o_b;
  logic [3:0] o_truth;
  logic [2:0] o_code;

  always #5 clk = ~clk;

  gate_classifier #(.SETTLE(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .dut_y(y1), .dut_a(a1), .dut_b(b1),
    .busy(busy1), .done(done1), .truth(truth1), .code(code1));
  gate_classifier #(.SETTLE(2)) u_s2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .dut_y(y2), .dut_a(a2), .dut_b(b2),
    .busy(busy2), .done(done2), .truth(truth2), .code(code2));

  // 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 tie-0, 7 tie-1, else arbitrary table
  function automatic logic gate_fn(input int gs, input logic a, input logic b, input logic [3:0] t);
    case (gs)
      0: return a & b;
      1: return a | b;
      2: return ~(a & b);
      3: return ~(a | b);
      4: return a ^ b;
      5: return ~(a ^ b);
      6: return 1'b0;
      7: return 1'b1;
      default: return t[{a, b}];
    endcase
  endfunction

  always @(posedge clk) begin
    yr1 <= gate_fn(g, a1, b1, tbl);
    yr2 <= gate_fn(g, a2, b2, tbl);
  end
  assign y1 = dly ? yr1 : gate_fn(g, a1, b1, tbl);
  assign y2 = dly ? yr2 : gate_fn(g, a2, b2, tbl);

  always_comb begin
    o_busy  = (sel == 2) ? busy2  : busy1;
    o_done  = (sel == 2) ? done2  : done1;
    o_a     = (sel == 2) ? a2     : a1;
    o_b     = (sel == 2) ? b2     : b1;
    o_truth = (sel == 2) ? truth2 : truth1;
    o_code  = (sel == 2) ? code2  : code1;
  end

  // A delayed gate seen with SETTLE=1 reports the previous vector's response.
  function automatic logic [3:0] model_truth(input int gs, input logic [3:0] t, input int s, input logic d);
    logic [3:0] r;
    logic [1:0] jv;
    for (int i = 0; i < 4; i++) begin
      jv = (d && s == 1) ? ((i == 0) ? 2'd0 : 2'(i - 1)) : 2'(i);
      r[i] = gate_fn(gs, jv[1], jv[0], t);
    end
    return r;
  endfunction

  function automatic logic [2:0] model_code(input logic [3:0] t);
    bit hit;
    for (int k = 0; k < 6; k++) begin
      hit = 1'b1;
      for (int i = 0; i < 4; i++) begin
        logic [1:0] v;
        v = 2'(i);
        if (gate_fn(k, v[1], v[0], 4'd0) != t[i]) hit = 1'b0;
      end
      if (hit) return 3'(k + 1);
    end
    return 3'd0;
  endfunction

  task automatic do_run(input int s);
    sel = s;
    vq.delete();
    lat = -1;
    busy_n = 0;
    @(negedge clk);
    if (s == 2) start2 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      if (o_busy) begin
        busy_n++;
        vq.push_back({o_a, o_b});
      end
      if (o_done) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start1 = 1'b1;
    start2 = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy1, done1, a1, b1, truth1, code1} !== 11'd0) begin
      errors++;
      $display("FAIL reset_s1 got busy=%b done=%b a=%b b=%b truth=%b code=%0d want all zero", busy1, done1, a1, b1, truth1, code1);
    end
    checks++;
    if ({busy2, done2, a2, b2, truth2, code2} !== 11'd0) begin
      errors++;
      $display("FAIL reset_s2 got busy=%b done=%b a=%b b=%b truth=%b code=%0d want all zero", busy2, done2, a2, b2, truth2, code2);
    end
    start1 = 1'b0;
    start2 = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_and();
    int bad = 0;
    g = 0;
    dly = 1'b0;
    do_run(2);
    checks++;
    if (lat != 9) begin errors++; $display("FAIL and_latency got %0d want 9", lat); end
    checks++;
    if (busy_n != 8) begin errors++; $display("FAIL and_busy_cycles got %0d want 8", busy_n); end
    foreach (vq[c]) if (vq[c] !== 2'(c / 2)) bad++;
    checks++;
    if (bad != 0 || vq.size() != 8) begin errors++; $display("FAIL and_vectors got %0d bad of %0d want 0 of 8", bad, vq.size()); end
    checks++;
    if (o_truth !== 4'b1000 || o_code !== 3'd1) begin
      errors++;
      $display("FAIL and_result got truth=%b code=%0d want 1000 1", o_truth, o_code);
    end
  endtask

  task automatic test_xor_xnor();
    g = 4;
    do_run(1);
    checks++;
    if (lat != 5 || o_truth !== 4'b0110 || o_code !== 3'd5) begin
      errors++;
      $display("FAIL xor got lat=%0d truth=%b code=%0d want 5 0110 5", lat, o_truth, o_code);
    end
    g = 5;
    do_run(1);
    checks++;
    if (lat != 5 || o_truth !== 4'b1001 || o_code !== 3'd6) begin
      errors++;
      $display("FAIL xnor got lat=%0d truth=%b code=%0d want 5 1001 6", lat, o_truth, o_code);
    end
  endtask

  task automatic test_const();
    g = 7;
    do_run(2);
    checks++;
    if (o_truth !== 4'b1111 || o_code !== 3'd0) begin
      errors++;
      $display("FAIL tie1 got truth=%b code=%0d want 1111 0", o_truth, o_code);
    end
    g = 6;
    do_run(2);
    checks++;
    if (o_truth !== 4'b0000 || o_code !== 3'd0) begin
      errors++;
      $display("FAIL tie0 got truth=%b code=%0d want 0000 0", o_truth, o_code);
    end
  endtask

  task automatic test_back_to_back();
    int dones = 0, last_d = -1, prev_done_c = -100;
    g = 3;
    sel = 2;
    @(negedge clk);
    start2 = 1'b1;
    for (int c = 1; c <= 200 && dones < 3; c++) begin
      @(negedge clk);
      if (c == prev_done_c + 1) begin
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0) begin
          errors++;
          $display("FAIL b2b_idle got busy=%b done=%b want 0 0", o_busy, o_done);
        end
      end
      if (c == prev_done_c + 2) begin
        checks++;
        if (o_busy !== 1'b1) begin errors++; $display("FAIL b2b_restart got busy=%b want 1", o_busy); end
      end
      if (o_done) begin
        checks++;
        if (o_truth !== 4'b0001 || o_code !== 3'd4) begin
          errors++;
          $display("FAIL b2b_result got truth=%b code=%0d want 0001 4", o_truth, o_code);
        end
        if (last_d >= 0) begin
          checks++;
          if (c - last_d != 10) begin errors++; $display("FAIL b2b_period got %0d want 10", c - last_d); end
        end
        last_d = c;
        prev_done_c = c;
        dones++;
      end
    end
    start2 = 1'b0;
    checks++;
    if (dones != 3) begin errors++; $display("FAIL b2b_count got %0d want 3", dones); end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset_midrun();
    int spur = 0;
    g = 1;
    do_run(2);
    checks++;
    if (o_code !== 3'd2) begin errors++; $display("FAIL prior_or got code=%0d want 2", o_code); end
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({o_a, o_b} !== 2'b10) begin errors++; $display("FAIL midrun_vector got %b want 10", {o_a, o_b}); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({o_busy, o_done, o_a, o_b, o_truth, o_code} !== 11'd0) begin
      errors++;
      $display("FAIL midrun_reset got busy=%b done=%b a=%b b=%b truth=%b code=%0d want all zero", o_busy, o_done, o_a, o_b, o_truth, o_code);
    end
    repeat (15) begin
      @(negedge clk);
      if (o_done || o_busy || o_code != 0) spur++;
    end
    checks++;
    if (spur != 0) begin errors++; $display("FAIL midrun_quiet got %0d active cycles want 0", spur); end
    do_run(2);
    checks++;
    if (lat != 9 || o_code !== 3'd2 || o_truth !== 4'b1110) begin
      errors++;
      $display("FAIL after_reset got lat=%0d truth=%b code=%0d want 9 1110 2", lat, o_truth, o_code);
    end
  endtask

  task automatic test_delay();
    g = 2;
    dly = 1'b1;
    do_run(1);
    checks++;
    if (o_truth !== model_truth(2, 4'd0, 1, 1'b1) || o_code !== 3'd0) begin
      errors++;
      $display("FAIL delay_s1 got truth=%b code=%0d want %b 0", o_truth, o_code, model_truth(2, 4'd0, 1, 1'b1));
    end
    do_run(2);
    checks++;
    if (o_truth !== 4'b0111 || o_code !== 3'd3) begin
      errors++;
      $display("FAIL delay_s2 got truth=%b code=%0d want 0111 3", o_truth, o_code);
    end
    dly = 1'b0;
  endtask

  task automatic test_random();
    int s, bad;
    logic [3:0] et;
    for (int n = 0; n < 24; n++) begin
      g = $urandom_range(0, 8);
      tbl = 4'($urandom);
      dly = 1'($urandom_range(0, 1));
      s = $urandom_range(1, 2);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_run(s);
      et = model_truth(g, tbl, s, dly);
      bad = 0;
      foreach (vq[c]) if (vq[c] !== 2'(c / s)) bad++;
      checks++;
      if (lat != 4 * s + 1 || busy_n != 4 * s || bad != 0) begin
        errors++;
        $display("FAIL rand_timing n=%0d got lat=%0d busy=%0d badvec=%0d want %0d %0d 0", n, lat, busy_n, bad, 4 * s + 1, 4 * s);
      end
      checks++;
      if (o_truth !== et || o_code !== model_code(et)) begin
        errors++;
        $display("FAIL rand_result n=%0d g=%0d s=%0d d=%b got truth=%b code=%0d want %b %0d", n, g, s, dly, o_truth, o_code, et, model_code(et));
      end
    end
    dly = 1'b0;
  endtask

  initial begin
    test_reset();
    test_and();
    test_xor_xnor();
    test_const();
    test_back_to_back();
    test_reset_midrun();
    test_delay();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
